// File: rtl/fft_pkg.sv
// Shared definitions for the 32-point FFT control path: state encoding,
// default sizes and the stage-index width seen by mux_control.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    UNLOAD  = 2'd3
  } fft_state_e;

  localparam int NUMSTAGES_DEF  = 5;
  localparam int NUMSAMPLES_DEF = 1 << NUMSTAGES_DEF;
  localparam int WL_DEF         = 16;
  // stage_num_r is a fixed 3-bit field at the mux_control boundary
  localparam int STAGEW         = 3;

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Handshake and control bundle between the FFT stage sequencer (slave side)
// and its frame source/sink plus mux_control (master side).
interface fft_stage_sequencer_if #(
  parameter int NUMSTAGES = fft_pkg::NUMSTAGES_DEF
) ();
  import fft_pkg::*;

  localparam int CNTW = NUMSTAGES - 2;

  logic                 start;
  logic                 abort;
  logic                 in_valid;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [NUMSTAGES-1:0] sample_addr;
  logic                 ld_data;
  logic [CNTW-1:0]      counter_r;
  logic [STAGEW-1:0]    stage_num_r;
  logic                 busy;
  logic                 done;

  modport slave (
    input  start, abort, in_valid, out_ready,
    output in_ready, out_valid, sample_addr, ld_data,
           counter_r, stage_num_r, busy, done
  );

  modport master (
    output start, abort, in_valid, out_ready,
    input  in_ready, out_valid, sample_addr, ld_data,
           counter_r, stage_num_r, busy, done
  );

endinterface

// File: rtl/fft_bitrev.sv
// Pure combinational W-bit reverse; maps a linear unload index onto the
// bit-reversed address so results leave in natural order.
module fft_bitrev #(
  parameter int W = fft_pkg::NUMSTAGES_DEF
) (
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  for (genvar gi = 0; gi < W; gi++) begin : g_rev
    assign o_q[gi] = i_d[W-1-gi];
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Frame sequencer LOAD -> COMPUTE -> UNLOAD for the pipelined FFT datapath.
// Optional macro FFT_SEQ_BITREV_EN: bit-reversed UNLOAD addressing.
module fft_stage_sequencer #(
  parameter int NUMSTAGES  = fft_pkg::NUMSTAGES_DEF,
  parameter int NUMSAMPLES = fft_pkg::NUMSAMPLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fft_stage_sequencer_if.slave   s_bus
);
  import fft_pkg::*;

  localparam int CNTW = NUMSTAGES - 2;

  localparam logic [NUMSTAGES-1:0] LAST_IDX = NUMSTAGES'(NUMSAMPLES - 1);
  localparam logic [NUMSTAGES-1:0] IDX_ONE  = NUMSTAGES'(1);
  localparam logic [CNTW-1:0]      CNT_ONE  = CNTW'(1);
  localparam logic [STAGEW-1:0]    STG_ONE  = STAGEW'(1);
  localparam logic [STAGEW-1:0]    LAST_STG = STAGEW'(NUMSTAGES - 1);

  fft_state_e           r_state, w_state_nxt;
  logic [NUMSTAGES-1:0] r_idx, w_idx_nxt;
  logic [NUMSTAGES-1:0] r_addr, w_addr_nxt, w_idx_view;
  logic [CNTW-1:0]      r_cnt, w_cnt_nxt;
  logic [STAGEW-1:0]    r_stage, w_stage_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_in_ready, r_out_valid, r_ld_data, r_busy;
  logic                 w_in_beat, w_out_beat;
  logic                 w_idx_last, w_cnt_last, w_stage_last;

  assign w_in_beat    = r_in_ready & s_bus.in_valid;
  assign w_out_beat   = r_out_valid & s_bus.out_ready;
  assign w_idx_last   = (r_idx == LAST_IDX);
  assign w_cnt_last   = (r_cnt == '1);
  assign w_stage_last = (r_stage == LAST_STG);

  // State and every output are registered from the next-state/next-value terms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_stage     <= '0;
      r_done      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_ld_data   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_addr      <= w_addr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_stage     <= w_stage_nxt;
      r_done      <= w_done_nxt;
      r_in_ready  <= (w_state_nxt == LOAD);
      r_out_valid <= (w_state_nxt == UNLOAD);
      r_ld_data   <= (w_state_nxt == LOAD);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (s_bus.abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (s_bus.start) w_state_nxt = LOAD;
        LOAD:    if (w_in_beat && w_idx_last) w_state_nxt = COMPUTE;
        COMPUTE: if (w_cnt_last && w_stage_last) w_state_nxt = UNLOAD;
        UNLOAD:  if (w_out_beat && w_idx_last) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Abort clears everything and suppresses done, even against a final beat.
  always_comb begin
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_stage_nxt = r_stage;
    w_done_nxt  = 1'b0;
    if (s_bus.abort) begin
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
      w_stage_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_stage_nxt = '0;
        end
        LOAD: begin
          if (w_in_beat) begin
            w_idx_nxt   = w_idx_last ? '0 : r_idx + IDX_ONE;
            w_cnt_nxt   = '0;
            w_stage_nxt = '0;
          end
        end
        COMPUTE: begin
          w_cnt_nxt = r_cnt + CNT_ONE;
          if (w_cnt_last) begin
            w_stage_nxt = w_stage_last ? '0 : r_stage + STG_ONE;
            w_idx_nxt   = '0;
          end
        end
        UNLOAD: begin
          if (w_out_beat) begin
            w_idx_nxt  = w_idx_last ? '0 : r_idx + IDX_ONE;
            w_done_nxt = w_idx_last;
          end
        end
        default: begin
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_stage_nxt = '0;
        end
      endcase
    end
  end

`ifdef FFT_SEQ_BITREV_EN
  fft_bitrev #(.W(NUMSTAGES)) u_bitrev (
    .i_d (w_idx_nxt),
    .o_q (w_idx_view)
  );
`else
  assign w_idx_view = w_idx_nxt;
`endif

  // Only the unload side sees the reordered address; loads stay linear.
  assign w_addr_nxt = (w_state_nxt == UNLOAD) ? w_idx_view : w_idx_nxt;

  assign s_bus.in_ready    = r_in_ready;
  assign s_bus.out_valid   = r_out_valid;
  assign s_bus.sample_addr = r_addr;
  assign s_bus.ld_data     = r_ld_data;
  assign s_bus.counter_r   = r_cnt;
  assign s_bus.stage_num_r = r_stage;
  assign s_bus.busy        = r_busy;
  assign s_bus.done        = r_done;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: stimulus pushes expected load,
// compute and unload events; a negedge monitor pops and compares them.
module tb_fft_stage_sequencer;
  import fft_pkg::*;

  localparam int NS    = 5;
  localparam int NSAMP = 32;
  localparam int NCNT  = 8;
  localparam int FRAME_CYC = 1 + NSAMP + NS * NCNT + NSAMP;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_stage_sequencer_if #(.NUMSTAGES(NS)) bus ();

  fft_stage_sequencer #(.NUMSTAGES(NS), .NUMSAMPLES(NSAMP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int lq[$];
  int cq[$];
  int uq[$];
  int pending_done = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Natural-order output needs bit-reversed addressing when enabled.
  function automatic int exp_uaddr(input int k);
`ifdef FFT_SEQ_BITREV_EN
    int r = 0;
    for (int b = 0; b < NS; b++) r = r * 2 + ((k >> b) % 2);
    return r;
`else
    return k;
`endif
  endfunction

  task automatic push_frame();
    for (int i = 0; i < NSAMP; i++) lq.push_back(i);
    for (int s = 0; s < NS; s++)
      for (int c = 0; c < NCNT; c++) cq.push_back(s * NCNT + c);
    for (int k = 0; k < NSAMP; k++) uq.push_back(exp_uaddr(k));
    pending_done++;
  endtask

  task automatic flush();
    lq.delete();
    cq.delete();
    uq.delete();
    pending_done = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every DUT-presented event is matched against the queue heads.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_ready && bus.in_valid) begin
        chk("load_expected", int'(lq.size() > 0), 1);
        if (lq.size() > 0) chk("load_addr", int'(bus.sample_addr), lq.pop_front());
        chk("load_ld_data", int'(bus.ld_data), 1);
      end
      if (bus.busy && !bus.in_ready && !bus.out_valid) begin
        chk("compute_expected", int'(cq.size() > 0), 1);
        if (cq.size() > 0)
          chk("stage_counter", int'(bus.stage_num_r) * NCNT + int'(bus.counter_r), cq.pop_front());
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("unload_expected", int'(uq.size() > 0), 1);
        if (uq.size() > 0) chk("unload_addr", int'(bus.sample_addr), uq.pop_front());
      end
      if (bus.done) begin
        chk("done_expected", int'(pending_done > 0), 1);
        if (pending_done > 0) pending_done--;
        chk("done_single", int'(prev_done), 0);
        chk("done_busy", int'(bus.busy), 0);
        chk("done_drained", lq.size() + cq.size() + uq.size(), 0);
      end
    end
    prev_done = bus.done;
  end

  // iv_mode: 0 tied high, 1 toggling 1010, 2 random. or_mode: 0 tied, 1 random.
  task automatic run_frame(input int iv_mode, input int or_mode, input int stall_at,
                           input bit poke, output int cyc);
    int ub = 0;
    int lb = 0;
    int stall = 0;
    int held = 0;
    bit got = 1'b0;
    push_frame();
    bus.start = 1'b1;
    cyc = 0;
    for (int t = 0; t < 3000; t++) begin
      if (cyc > 0) bus.start = 1'b0;
      case (iv_mode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = (cyc % 2 == 0);
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      if (bus.out_valid && ub == stall_at && stall < 3) begin
        bus.out_ready = 1'b0;
        if (stall == 0) begin
          held = int'(bus.sample_addr);
          chk("stall_addr", held, exp_uaddr(stall_at));
        end else begin
          chk("stall_hold", int'(bus.sample_addr), held);
        end
        stall++;
      end else begin
        bus.out_ready = (or_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (poke && cyc > 0 && ((bus.in_ready && lb == 10) || (bus.out_valid && ub == 10)))
        bus.start = 1'b1;
      if (bus.in_ready && bus.in_valid) lb++;
      if (bus.out_valid && bus.out_ready) ub++;
      tick();
      cyc++;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    chk("frame_done_seen", int'(got), 1);
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
  endtask

  initial begin
    int cyc;
    bit found;
    int ucnt;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_ld_data", int'(bus.ld_data), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_counter", int'(bus.counter_r), 0);
    chk("rst_stage", int'(bus.stage_num_r), 0);
    chk("rst_addr", int'(bus.sample_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_in_ready", int'(bus.in_ready), 0);

    // Full frame with tied handshakes
    run_frame(0, 0, -1, 1'b0, cyc);
    chk("frame_cycles", cyc, FRAME_CYC);

    // Input toggling plus a 3-cycle output stall at index 5
    run_frame(1, 0, 5, 1'b0, cyc);

    // Random handshakes
    for (int n = 0; n < 3; n++) run_frame(2, 1, -1, 1'b0, cyc);

    // Start pulses while busy must be ignored
    run_frame(2, 1, -1, 1'b1, cyc);

    // start and abort together in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", int'(bus.busy), 0);
    tick();
    chk("start_abort_in_ready", int'(bus.in_ready), 0);

    // Abort in COMPUTE at stage 2 counter 3
    push_frame();
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 200; t++) begin
      tick();
      bus.start = 1'b0;
      if (bus.busy && !bus.in_ready && bus.stage_num_r == 3'd2 && bus.counter_r == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_point_reached", int'(found), 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    flush();
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_counter", int'(bus.counter_r), 0);
    chk("abort_stage", int'(bus.stage_num_r), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_out_valid", int'(bus.out_valid), 0);
    repeat (4) tick();
    run_frame(0, 0, -1, 1'b0, cyc);
    chk("post_abort_cycles", cyc, FRAME_CYC);

    // Asynchronous reset mid-UNLOAD
    push_frame();
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    ucnt = 0;
    for (int t = 0; t < 300; t++) begin
      tick();
      bus.start = 1'b0;
      if (bus.out_valid) ucnt++;
      if (ucnt == 8) break;
    end
    chk("unload_reached", ucnt, 8);
    rst_n = 1'b0;
    flush();
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_out_valid", int'(bus.out_valid), 0);
    chk("arst_addr", int'(bus.sample_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_idle", int'(bus.busy), 0);
    run_frame(0, 0, -1, 1'b0, cyc);
    chk("post_rst_cycles", cyc, FRAME_CYC);

    repeat (3) tick();
    chk("final_pending_done", pending_done, 0);
    chk("final_queues", lq.size() + cq.size() + uq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
